// File: rtl/ps2_key_packer.sv
// ----------------------------------------------------------------------------
// ps2_key_packer
//   Packs a PS/2 scan-code byte stream into a 65-bit key event word. The word
//   is updated once per complete make/break sequence. This includes plain
//   codes, E0-extended codes, and the PRNSCR and PAUSE sequences.
//
// Ports
//   clk_sys     in   1  system clock, rising edge
//   reset_n     in   1  synchronous active-low reset
//   byte_in     in   8  received scan-code byte
//   byte_valid  in   1  one-cycle qualifier for byte_in
//   ps2_key     out 65  [63:0] right-aligned sequence, [64] toggles per event
//   key_strobe  out  1  one-cycle pulse with each ps2_key update
//   busy        out  1  a partial sequence is being held
// ----------------------------------------------------------------------------
module ps2_key_packer #(
   parameter int unsigned TIMEOUT_CYCLES = 1000000,
   parameter bit          FILTER_RESP    = 1'b1
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic [7:0]  byte_in,
   input  logic        byte_valid,
   output logic [64:0] ps2_key,
   output logic        key_strobe,
   output logic        busy
);

   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
   // The partial sequence is dropped on the edge where the counter would reach
   // TIMEOUT_CYCLES-1.
   localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT_CYCLES - 2);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COLLECT = 2'd1,
      S_PAUSE   = 2'd2
   } state_t;

   function automatic logic is_prefix(input logic [7:0] b);
      return (b == 8'hE0) || (b == 8'hF0) || (b == 8'hE1);
   endfunction

   function automatic logic is_resp(input logic [7:0] b);
      return (b == 8'h00) || (b == 8'hAA) || (b == 8'hEE) ||
             (b == 8'hFA) || (b == 8'hFE) || (b == 8'hFF);
   endfunction

   state_t         state_q, state_d;
   logic [63:0]    acc_q, acc_d;
   logic [3:0]     cnt_q, cnt_d;
   logic [TW-1:0]  tmr_q, tmr_d;
   logic [64:0]    key_q, key_d;
   logic           strobe_q, strobe_d;
   logic           busy_q;

   logic [63:0]    shifted_s;
   logic           timeout_s;
   logic           fresh_s;
   logic           done_s;
   logic [63:0]    done_word_s;

   assign shifted_s = {acc_q[55:0], byte_in};
   assign timeout_s = (state_q != S_IDLE) && (tmr_q == TMR_LAST);
   // These bytes start a new sequence: bytes in idle, a byte on the timeout
   // cycle, and a 9th byte outside PAUSE (overflow).
   assign fresh_s   = (state_q == S_IDLE) || timeout_s ||
                      ((state_q == S_COLLECT) && (cnt_q == 4'd8));

   // Next-state, accumulator, timeout counter and event word logic.
   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      tmr_d       = tmr_q;
      key_d       = key_q;
      strobe_d    = 1'b0;
      done_s      = 1'b0;
      done_word_s = 64'd0;

      if (byte_valid) begin
         tmr_d = '0;
         if (fresh_s) begin
            state_d = S_IDLE;
            acc_d   = 64'd0;
            cnt_d   = 4'd0;
            if (FILTER_RESP && is_resp(byte_in)) begin
               state_d = S_IDLE;
            end else if (byte_in == 8'hE1) begin
               state_d = S_PAUSE;
               acc_d   = {56'd0, byte_in};
               cnt_d   = 4'd1;
            end else if (is_prefix(byte_in)) begin
               state_d = S_COLLECT;
               acc_d   = {56'd0, byte_in};
               cnt_d   = 4'd1;
            end else begin
               done_s      = 1'b1;
               done_word_s = {56'd0, byte_in};
            end
         end else if (state_q == S_PAUSE) begin
            // PAUSE has fixed length, so its byte values do not matter.
            if (cnt_q == 4'd7) begin
               done_s      = 1'b1;
               done_word_s = shifted_s;
            end else begin
               acc_d = shifted_s;
               cnt_d = cnt_q + 4'd1;
            end
         end else begin
            // E0 12 and E0 F0 7C are the first halves of PRNSCR make and
            // break, so they do not end the sequence.
            if (!is_prefix(byte_in) &&
                !((cnt_q == 4'd1) && (acc_q == 64'h0000_0000_0000_00E0) && (byte_in == 8'h12)) &&
                !((cnt_q == 4'd2) && (acc_q == 64'h0000_0000_0000_E0F0) && (byte_in == 8'h7C))) begin
               done_s      = 1'b1;
               done_word_s = shifted_s;
            end else begin
               acc_d = shifted_s;
               cnt_d = cnt_q + 4'd1;
            end
         end
      end else if (timeout_s) begin
         state_d = S_IDLE;
         acc_d   = 64'd0;
         cnt_d   = 4'd0;
         tmr_d   = '0;
      end else if (state_q != S_IDLE) begin
         tmr_d = tmr_q + TW'(1);
      end else begin
         tmr_d = '0;
      end

      if (done_s) begin
         key_d    = {~key_q[64], done_word_s};
         strobe_d = 1'b1;
         state_d  = S_IDLE;
         acc_d    = 64'd0;
         cnt_d    = 4'd0;
      end else begin
         strobe_d = 1'b0;
      end
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         acc_q    <= 64'd0;
         cnt_q    <= 4'd0;
         tmr_q    <= '0;
         key_q    <= 65'd0;
         strobe_q <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         tmr_q    <= tmr_d;
         key_q    <= key_d;
         strobe_q <= strobe_d;
         busy_q   <= (state_d != S_IDLE);
      end
   end

   assign ps2_key    = key_q;
   assign key_strobe = strobe_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_ps2_key_packer.sv
// ----------------------------------------------------------------------------
// tb_ps2_key_packer
//   Directed and randomized stimulus for ps2_key_packer. A sequence-level
//   reference model tracks the held bytes in a queue. The DUT outputs are
//   compared against this model after every clock edge.
// ----------------------------------------------------------------------------
module tb_ps2_key_packer;

   localparam int unsigned T = 16;

   logic        clk_sys = 1'b0;
   logic        reset_n = 1'b0;
   logic [7:0]  byte_in = 8'd0;
   logic        byte_valid = 1'b0;
   logic [64:0] ps2_key;
   logic        key_strobe;
   logic        busy;

   int checks = 0;
   int failures = 0;
   int n_events = 0;

   // reference model state
   logic [7:0]  seq[$];
   int          silent = 0;
   logic [64:0] exp_key = 65'd0;
   logic        exp_strobe = 1'b0;

   ps2_key_packer #(.TIMEOUT_CYCLES(T), .FILTER_RESP(1'b1)) dut (
      .clk_sys    (clk_sys),
      .reset_n    (reset_n),
      .byte_in    (byte_in),
      .byte_valid (byte_valid),
      .ps2_key    (ps2_key),
      .key_strobe (key_strobe),
      .busy       (busy)
   );

   always #5 clk_sys = ~clk_sys;

   initial begin
      #2000000;
      $display("FAIL watchdog expired got=running required=finished");
      $fatal(1, "watchdog");
   end

   function automatic logic m_prefix(input logic [7:0] b);
      return (b == 8'hE0) || (b == 8'hF0) || (b == 8'hE1);
   endfunction

   function automatic logic m_resp(input logic [7:0] b);
      return (b == 8'h00) || (b == 8'hAA) || (b == 8'hEE) ||
             (b == 8'hFA) || (b == 8'hFE) || (b == 8'hFF);
   endfunction

   // One clock edge of the reference model.
   task automatic model_edge(input logic rn, input logic v, input logic [7:0] b);
      logic        done;
      logic [63:0] w;
      exp_strobe = 1'b0;
      if (!rn) begin
         seq.delete();
         silent  = 0;
         exp_key = 65'd0;
         return;
      end
      if (seq.size() != 0 && silent == int'(T) - 2) begin
         seq.delete();
      end
      if (v) begin
         silent = 0;
         if (seq.size() == 8 && seq[0] != 8'hE1) seq.delete();
         if (!(seq.size() == 0 && m_resp(b))) begin
            seq.push_back(b);
            if (seq[0] == 8'hE1)
               done = (seq.size() == 8);
            else
               done = !m_prefix(b) &&
                      !(seq.size() == 2 && seq[0] == 8'hE0 && seq[1] == 8'h12) &&
                      !(seq.size() == 3 && seq[0] == 8'hE0 && seq[1] == 8'hF0 && seq[2] == 8'h7C);
            if (done) begin
               w = 64'd0;
               foreach (seq[i]) w = {w[55:0], seq[i]};
               exp_key    = {~exp_key[64], w};
               exp_strobe = 1'b1;
               seq.delete();
            end
         end
      end else begin
         silent = (seq.size() != 0) ? silent + 1 : 0;
      end
   endtask

   task automatic check_lit(input string name, input logic [64:0] got, input logic [64:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h required=%h", name, got, exp);
      end
   endtask

   // Drive one cycle, advance the model, and compare all outputs after the edge.
   task automatic step(input logic rn, input logic v, input logic [7:0] b);
      reset_n = rn; byte_valid = v; byte_in = b;
      @(posedge clk_sys);
      model_edge(rn, v, b);
      #1;
      checks++;
      if (ps2_key !== exp_key) begin
         failures++;
         $display("FAIL model_ps2_key t=%0t got=%h required=%h", $time, ps2_key, exp_key);
      end
      checks++;
      if (key_strobe !== exp_strobe) begin
         failures++;
         $display("FAIL model_key_strobe t=%0t got=%b required=%b", $time, key_strobe, exp_strobe);
      end
      checks++;
      if (busy !== (seq.size() != 0)) begin
         failures++;
         $display("FAIL model_busy t=%0t got=%b required=%b", $time, busy, seq.size() != 0);
      end
      if (key_strobe === 1'b1) n_events++;
      reset_n = 1'b1; byte_valid = 1'b0;
   endtask

   task automatic send(input logic [7:0] b);
      step(1'b1, 1'b1, b);
   endtask

   initial begin
      int n0;
      int busy_cnt;
      logic [7:0] pool [12];
      pool = '{8'hE0, 8'hF0, 8'hE1, 8'h12, 8'h7C, 8'h1C,
               8'h75, 8'hFA, 8'hAA, 8'h00, 8'h14, 8'h77};

      step(1'b0, 1'b0, 8'd0);
      step(1'b0, 1'b0, 8'd0);
      check_lit("reset_key", ps2_key, 65'd0);
      check_lit("reset_busy_strobe", {63'd0, busy, key_strobe}, 65'd0);

      // plain make / break
      n0 = n_events;
      send(8'h1C);
      check_lit("make_1c", ps2_key, {1'b1, 64'h1C});
      check_lit("make_strobe", {64'd0, key_strobe}, 65'd1);
      send(8'hF0); send(8'h1C);
      check_lit("break_f01c", ps2_key, {1'b0, 64'hF01C});
      check_lit("makebreak_events", 65'(n_events - n0), 65'd2);

      // extended keys
      n0 = n_events;
      send(8'hE0); send(8'h75);
      check_lit("ext_make", {49'd0, ps2_key[15:0]}, 65'hE075);
      send(8'hE0); send(8'hF0); send(8'h75);
      check_lit("ext_break", {41'd0, ps2_key[23:0]}, 65'hE0F075);
      check_lit("ext_events", 65'(n_events - n0), 65'd2);

      // long sequences
      n0 = n_events;
      send(8'hE0); send(8'h12); send(8'hE0); send(8'h7C);
      check_lit("prnscr_make", {33'd0, ps2_key[31:0]}, 65'hE012E07C);
      send(8'hE0); send(8'hF0); send(8'h7C); send(8'hE0); send(8'hF0); send(8'h12);
      check_lit("prnscr_break", {17'd0, ps2_key[47:0]}, 65'hE0F07CE0F012);
      send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
      send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
      check_lit("pause", {1'b0, ps2_key[63:0]}, 65'hE11477E1F014F077);
      check_lit("long_events", 65'(n_events - n0), 65'd3);

      // response filtering
      n0 = n_events;
      send(8'hFA);
      check_lit("filter_fa_busy", {64'd0, busy}, 65'd0);
      send(8'hAA);
      check_lit("filter_aa_busy", {64'd0, busy}, 65'd0);
      check_lit("filter_events", 65'(n_events - n0), 65'd0);
      send(8'h1C);
      check_lit("filter_then_1c", {1'b0, ps2_key[63:0]}, 65'h1C);

      // timeout
      n0 = n_events;
      send(8'hE0);
      busy_cnt = (busy === 1'b1) ? 1 : 0;
      for (int i = 0; i < 20; i++) begin
         step(1'b1, 1'b0, 8'd0);
         if (busy === 1'b1) busy_cnt++;
      end
      check_lit("timeout_busy_cycles", 65'(busy_cnt), 65'd15);
      send(8'h75);
      check_lit("timeout_result", {1'b0, ps2_key[63:0]}, 65'h75);
      check_lit("timeout_events", 65'(n_events - n0), 65'd1);

      // overflow
      n0 = n_events;
      for (int i = 0; i < 9; i++) send(8'hE0);
      check_lit("overflow_no_event", 65'(n_events - n0), 65'd0);
      check_lit("overflow_busy", {64'd0, busy}, 65'd1);
      send(8'h75);
      check_lit("overflow_result", {1'b0, ps2_key[63:0]}, 65'hE075);

      // reset mid-sequence
      send(8'hE0); send(8'hF0);
      step(1'b0, 1'b0, 8'd0);
      check_lit("midreset_key", ps2_key, 65'd0);
      check_lit("midreset_busy_strobe", {63'd0, busy, key_strobe}, 65'd0);
      send(8'h1C);
      check_lit("after_reset_1c", ps2_key, {1'b1, 64'h1C});

      // randomized traffic
      for (int i = 0; i < 4000; i++) begin
         int r;
         r = int'($urandom_range(0, 99));
         if (r < 1) begin
            step(1'b0, 1'b0, 8'd0);
         end else if (r < 60) begin
            if ($urandom_range(0, 15) < 12)
               send(pool[$urandom_range(0, 11)]);
            else
               send(8'($urandom));
         end else if (r < 96) begin
            step(1'b1, 1'b0, 8'd0);
         end else begin
            for (int j = 0; j < int'($urandom_range(8, 20)); j++) step(1'b1, 1'b0, 8'd0);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
